packet_arbiter_multiplexer: RTL
===============================

Name: packet_arbiter_multiplexer

Overview:
- Downstream consumer of the timeout static-priority arbiter: merges SIZE valid/ready input streams onto one output stream.
- Arbitrates only at packet boundaries and holds the grant until the packet's `last` beat has been accepted.
- Registers the output through a one-entry pipeline stage.
- Sits in front of shared sinks such as bus bridges and FIFOs that multiple masters need packet-atomic access to.

Parameters:
- SIZE, 4, number of input channels (≥2); channel 0 has the highest static priority.
- WIDTH, 32, data width per beat.
- VARIANT, "fast", passed to the arbiter.
- TIMEOUT, 8, passed to the arbiter; number of arbitration slots a channel can lose before it is promoted.

Ports:
- clock  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  SIZE  per-channel beat valid.
- in_ready  out  SIZE  per-channel beat accepted; one-hot or zero.
- in_data  in  SIZE*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  SIZE  per-channel end-of-packet marker.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  registered output data.
- out_last  out  1  registered end-of-packet marker.

Behaviour:
- Reset is asynchronous, active-low (resetn); clock is clock.
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - in_ready=0.
  - State=IDLE, lock register=0.
  - Arbiter timeout counters are reset by the arbiter itself.
- Pipeline rule: accept = !out_valid || out_ready.
  - A beat handshakes on channel i when in_valid[i] && in_ready[i].
  - The output register loads that beat on the same edge.
  - Latency: input handshake → out_valid next cycle.
  - If there is no handshake and out_ready=1, out_valid clears.
- FSM IDLE:
  - Arbiter requests = in_valid when accept=1, else 0, so arbiter counters age only on real arbitration slots.
  - in_ready = arbiter grant when accept=1, else 0.
  - On handshake with last=1: stay IDLE.
  - On handshake with last=0: latch grant into the lock register and go to LOCKED.
- FSM LOCKED:
  - Arbiter requests = 0.
  - in_ready = lock & {SIZE{accept}}.
  - Other channels wait; their in_valid is ignored.
  - On a handshake of the locked channel with last=1: go to IDLE and clear the lock.
  - A single-beat packet never enters LOCKED.
- Back-to-back: a channel finishing a packet competes in the very next cycle's arbitration like any other channel; there is no bubble when accept=1.
- Locked channel deasserts in_valid mid-packet: stay LOCKED indefinitely. There is no watchdog and other channels are blocked.
- out_ready=0 with out_valid=1: no input handshakes; the output register is held stable (data/last unchanged).
- Reset mid-packet: FSM returns to IDLE; the partial packet is dropped; out_valid=0.
- Inputs are sampled only when valid; data on unselected channels is don't-care.

Optional Feature:
- Macro: PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN.
- With the macro defined:
  - Adds output port out_channel, width CLOG2(SIZE), registered alongside out_data.
  - Carries the binary index of the source channel; reset value 0.
- Without the macro: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state enum {IDLE, LOCKED}; CHANNEL_INDEX_WIDTH = CLOG2(SIZE) helper; one-hot-to-binary function used for out_channel.
- Sub-module: instantiate the existing timout_static_priority_arbiter for grant generation.
- Sub-module: factor the output pipeline register into a new pipeline_register stage (WIDTH+1 bits plus the optional ID).

Test Plan:
- Single-beat contention:
  - Stimulus: SIZE=4, all in_valid=1, every in_last=1, out_ready=1.
  - Required response: beats from ch0 each cycle, then ch1..3 served by timeout.
    - ch3 first appears within 9 slots; no cycle carries two in_ready.
- Packet lock:
  - Stimulus: ch2 sends a 4-beat packet (last on beat 4); ch0 asserts valid at beat 2.
  - Required response: out carries ch2 beats 1–4 contiguously, then ch0 in the next slot.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-packet.
  - Required response: out_data/out_last stable, in_ready=0, no beat lost or duplicated; beat order preserved after release.
- Mid-packet stall:
  - Stimulus: locked ch1 drops valid for 3 cycles while ch0 is valid.
  - Required response: ch0 gets no in_ready until ch1 completes its last beat.
- Reset mid-packet:
  - Stimulus: resetn pulse during beat 2 of a 3-beat packet.
  - Required response: out_valid=0 immediately; after reset a fresh arbitration occurs and ch0 wins.
- CHANNEL_ID_EN:
  - Stimulus: ch3 single beat, data 0xDEADBEEF.
  - Required response: out_data=0xDEADBEEF, out_channel=3, one cycle after the handshake.

Source files
------------

// File: rtl/packet_arbiter_multiplexer_pkg.sv
// Shared types and helpers for the packet arbiter multiplexer.
// PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN uses onehot_to_bin for out_channel.
package packet_arbiter_multiplexer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int MAX_CHANNELS = 32;

  function automatic int chan_idx_w(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

  function automatic int unsigned onehot_to_bin(input logic [MAX_CHANNELS-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipeline_register.sv
// One-entry output stage: loads on i_load, drains when the consumer is ready.
module pipeline_register #(
  parameter int W = 33
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_load,
  input  logic         i_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/timout_static_priority_arbiter.sv
// Static-priority arbiter (channel 0 highest) with per-channel starvation counters;
// a channel that loses TIMEOUT slots in a row is promoted above the static order.
module timout_static_priority_arbiter #(
  parameter int    SIZE    = 4,
  parameter string VARIANT = "fast",
  parameter int    TIMEOUT = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [SIZE-1:0] i_request,
  output logic [SIZE-1:0] o_grant
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // "fast" serves the highest-index promoted channel first, draining the deepest-starved ones.
  localparam bit FAST  = (VARIANT == "fast");

  logic [CNT_W-1:0] r_count [SIZE];
  logic [SIZE-1:0]  w_promoted;

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_promoted[i] = i_request[i] && (r_count[i] == CNT_W'(TIMEOUT));
    end
  end

  always_comb begin
    o_grant = '0;
    if (|w_promoted) begin
      if (FAST) begin
        for (int i = 0; i < SIZE; i++) begin
          if (w_promoted[i]) begin
            o_grant    = '0;
            o_grant[i] = 1'b1;
          end
        end
      end else begin
        for (int i = SIZE - 1; i >= 0; i--) begin
          if (w_promoted[i]) begin
            o_grant    = '0;
            o_grant[i] = 1'b1;
          end
        end
      end
    end else begin
      for (int i = SIZE - 1; i >= 0; i--) begin
        if (i_request[i]) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SIZE; i++) r_count[i] <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (i_request[i] && !o_grant[i]) begin
          if (r_count[i] != CNT_W'(TIMEOUT)) r_count[i] <= r_count[i] + 1'b1;
        end else begin
          r_count[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/packet_arbiter_multiplexer.sv
// Packet-atomic N:1 stream multiplexer with registered output.
// Optional PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN adds out_channel (source index).
module packet_arbiter_multiplexer
  import packet_arbiter_multiplexer_pkg::*;
#(
  parameter int    SIZE    = 4,
  parameter int    WIDTH   = 32,
  parameter string VARIANT = "fast",
  parameter int    TIMEOUT = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [SIZE-1:0]             in_valid,
  output logic [SIZE-1:0]             in_ready,
  input  logic [SIZE*WIDTH-1:0]       in_data,
  input  logic [SIZE-1:0]             in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
`ifdef PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN
  output logic [chan_idx_w(SIZE)-1:0] out_channel,
`endif
  output logic                        out_last
);

  localparam int CH_W = chan_idx_w(SIZE);
`ifdef PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN
  localparam int PW = WIDTH + 1 + CH_W;
`else
  localparam int PW = WIDTH + 1;
`endif

  state_t           r_state, w_next_state;
  logic [SIZE-1:0]  r_lock, w_next_lock;
  logic [SIZE-1:0]  w_req, w_grant, w_hs_vec;
  logic             w_accept, w_hs, w_out_valid, w_sel_last;
  logic [WIDTH-1:0] w_sel_data;
  logic [PW-1:0]    w_pipe_in, w_pipe_out;

  assign w_accept = !w_out_valid || out_ready;
  // Requests are masked outside real arbitration slots so timeout counters do not age.
  assign w_req    = (r_state == IDLE && w_accept) ? in_valid : '0;
  assign w_hs_vec = in_valid & in_ready;
  assign w_hs     = |w_hs_vec;

  timout_static_priority_arbiter #(
    .SIZE    (SIZE),
    .VARIANT (VARIANT),
    .TIMEOUT (TIMEOUT)
  ) u_arbiter (
    .clock     (clock),
    .resetn    (resetn),
    .i_request (w_req),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_next_state;
      r_lock  <= w_next_lock;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_lock  = r_lock;
    case (r_state)
      IDLE: begin
        if (w_hs && !w_sel_last) begin
          w_next_state = LOCKED;
          w_next_lock  = w_hs_vec;
        end
      end
      LOCKED: begin
        if (w_hs && w_sel_last) begin
          w_next_state = IDLE;
          w_next_lock  = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_lock  = '0;
      end
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (resetn) begin
      if (r_state == IDLE) in_ready = w_accept ? w_grant : '0;
      else                 in_ready = r_lock & {SIZE{w_accept}};
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (w_hs_vec[i]) begin
        w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
        w_sel_last = w_sel_last | in_last[i];
      end
    end
  end

`ifdef PACKET_ARBITER_MULTIPLEXER_CHANNEL_ID_EN
  assign w_pipe_in   = {CH_W'(onehot_to_bin(MAX_CHANNELS'(w_hs_vec))), w_sel_last, w_sel_data};
  assign out_channel = w_pipe_out[PW-1 -: CH_W];
`else
  assign w_pipe_in   = {w_sel_last, w_sel_data};
`endif

  pipeline_register #(
    .W (PW)
  ) u_out_stage (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_hs),
    .i_ready (out_ready),
    .i_data  (w_pipe_in),
    .o_valid (w_out_valid),
    .o_data  (w_pipe_out)
  );

  assign out_valid = w_out_valid;
  assign out_data  = w_pipe_out[WIDTH-1:0];
  assign out_last  = w_pipe_out[WIDTH];

endmodule
